// File: rtl/psram_arb.sv
// psram_arb: round-robin arbiter and timing sequencer for a 16-bit async PSRAM.
// Byte-wide requests from NCH masters are served one at a time with
// programmable read/write wait states and an idle turnaround after each ack.
module psram_arb #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned RD_WAIT = 4,
    parameter int unsigned WR_WAIT = 4,
    parameter int unsigned TURN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_rd,
    input  logic [NCH-1:0]        req_wr,
    input  logic [NCH*ADDR_W-1:0] req_a,
    input  logic [NCH*8-1:0]      req_din,
    output logic [NCH-1:0]        req_ack,
    output logic [7:0]            req_dout,
    output logic                  busy,
    output logic [2:0]            grant,
    output logic [21:0]           ram_a,
    input  logic [15:0]           ram_dq_i,
    output logic [15:0]           ram_dq_o,
    output logic                  ram_dq_oe,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic                  ram_lb_n,
    output logic                  ram_ub_n
);

    localparam int unsigned CntW = 16;

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StTurn} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              wr_q, wr_d;

    logic [NCH-1:0]    ack_q, ack_d;
    logic [7:0]        dout_q, dout_d;
    logic              busy_q, busy_d;
    logic [21:0]       ram_a_q, ram_a_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              lb_n_q, lb_n_d, ub_n_q, ub_n_d;

    // Per-channel views padded to 8 entries so a 3-bit index always fits.
    logic [ADDR_W-1:0] a_arr [8];
    logic [7:0]        d_arr [8];
    logic [7:0]        rq, wq;

    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < NCH) begin : g_used
            assign a_arr[g] = req_a[g*ADDR_W +: ADDR_W];
            assign d_arr[g] = req_din[g*8 +: 8];
            assign rq[g]    = req_rd[g] | req_wr[g];
            assign wq[g]    = req_wr[g];
        end else begin : g_unused
            assign a_arr[g] = '0;
            assign d_arr[g] = '0;
            assign rq[g]    = 1'b0;
            assign wq[g]    = 1'b0;
        end
    end

    logic       found;
    logic [2:0] win;

    // Round-robin search upward from the channel after the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 1; k <= int'(NCH); k++) begin
            logic [2:0] idx;
            idx = 3'((int'(ptr_q) + k) % int'(NCH));
            if (!found && rq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= 3'(NCH - 1);
            grant_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
        end
    end

    // Next state: grant in IDLE, count wait states, then DONE and optional TURN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_d    = wr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    ptr_d   = win;
                    grant_d = win;
                    addr_d  = a_arr[win];
                    din_d   = d_arr[win];
                    wr_d    = wq[win];
                    cnt_d   = wq[win] ? CntW'(WR_WAIT - 1) : CntW'(RD_WAIT - 1);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDone: begin
                if (TURN > 0) begin
                    state_d = StTurn;
                    cnt_d   = CntW'(TURN - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StTurn: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    logic [7:0] ack_sel;

    // Output next values derived from the upcoming state so every pin is a flop.
    always_comb begin
        ack_sel = 8'b1 << grant_q;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ram_a_d = ram_a_q;
        dq_o_d  = dq_o_q;
        ack_d   = '0;
        dout_d  = '0;
        busy_d  = (state_d != StIdle);
        if (state_d == StAccess) begin
            ram_a_d = 22'(addr_d[ADDR_W-1:1]);
            ce_n_d  = 1'b0;
            ub_n_d  = !addr_d[0];
            lb_n_d  = addr_d[0];
            if (wr_d) begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                dq_o_d  = {din_d, din_d};
            end else begin
                oe_n_d  = 1'b0;
            end
        end
        // DONE is only entered from ACCESS, so this samples on the last ACCESS edge.
        if (state_d == StDone) begin
            ack_d = ack_sel[NCH-1:0];
            if (!wr_q) dout_d = addr_q[0] ? ram_dq_i[15:8] : ram_dq_i[7:0];
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            ram_a_q <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
        end else begin
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            ram_a_q <= ram_a_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
        end
    end

    assign req_ack   = ack_q;
    assign req_dout  = dout_q;
    assign busy      = busy_q;
    assign grant     = grant_q;
    assign ram_a     = ram_a_q;
    assign ram_dq_o  = dq_o_q;
    assign ram_dq_oe = dq_oe_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign ram_lb_n  = lb_n_q;
    assign ram_ub_n  = ub_n_q;

endmodule
